// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the execute stage.
// Signed/unsigned, XLEN or 32-bit word mode, valid/ready both sides.
module div_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] op_1_i,
  input  logic [XLEN-1:0] op_2_i,
  input  logic            signed_i,
  input  logic            word_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            nq_q, nq_d;
  logic            nr_q, nr_d;
  logic            wd_q, wd_d;
  logic [XLEN-1:0] quo_d, rmd_d;

  function automatic logic [XLEN-1:0] sx32(
    input logic [31:0] v
  );
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] fix(
    input logic [XLEN-1:0] v,
    input logic            neg,
    input logic            w
  );
    logic [XLEN-1:0] t;
    t = neg ? -v : v;
    return w ? sx32(t[31:0]) : t;
  endfunction

  logic            wd;
  logic [XLEN-1:0] op1_n, op2_n;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN-1:0] min_n;
  logic            s1, s2;
  logic            div0, ovf;

  // Word operands are widened first so one XLEN-wide abs serves both modes
  always_comb begin
    wd = (XLEN == 64) && word_i;
    if (wd) begin
      op1_n = signed_i ? sx32(op_1_i[31:0])
                       : XLEN'(op_1_i[31:0]);
      op2_n = signed_i ? sx32(op_2_i[31:0])
                       : XLEN'(op_2_i[31:0]);
      min_n = sx32(32'h8000_0000);
      div0  = (op_2_i[31:0] == 32'h0);
    end else begin
      op1_n = op_1_i;
      op2_n = op_2_i;
      min_n = XLEN'(1) << (XLEN - 1);
      div0  = (op_2_i == '0);
    end
    s1   = signed_i && op1_n[XLEN-1];
    s2   = signed_i && op2_n[XLEN-1];
    abs1 = s1 ? -op1_n : op1_n;
    abs2 = s2 ? -op2_n : op2_n;
    ovf  = signed_i && (op1_n == min_n)
        && (op2_n == '1);
  end

  logic [XLEN:0]   rem_sh, trial;
  logic            qbit;
  logic [XLEN-1:0] rem_nx, dvd_nx;

  always_comb begin
    rem_sh = {rem_q, dvd_q[XLEN-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    qbit   = ~trial[XLEN];
    rem_nx = qbit ? trial[XLEN-1:0]
                  : rem_sh[XLEN-1:0];
    dvd_nx = {dvd_q[XLEN-2:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    wd_d    = wd_q;
    quo_d   = quotient_o;
    rmd_d   = remainder_o;
    req_ready_o  = (state_q == IDLE)
                && !stall_i && !flush_i;
    resp_valid_o = (state_q == DONE)
                && !stall_i && !flush_i;
    if (flush_i) begin
      state_d = IDLE;
    end else if (!stall_i) begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            wd_d = wd;
            if (div0) begin
              quo_d   = '1;
              rmd_d   = fix(op_1_i, 1'b0, wd);
              state_d = DONE;
            end else if (ovf) begin
              quo_d   = fix(op_1_i, 1'b0, wd);
              rmd_d   = '0;
              state_d = DONE;
            end else begin
              // Word dividends are left-aligned so
              // the next bit is always the MSB
              cnt_d   = wd ? CW'(31) : CW'(XLEN-1);
              rem_d   = '0;
              dvd_d   = wd ? (abs1 << (XLEN - 32))
                           : abs1;
              dvs_d   = abs2;
              nq_d    = s1 ^ s2;
              nr_d    = s1;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = rem_nx;
          dvd_d = dvd_nx;
          if (cnt_q == '0) begin
            quo_d   = fix(dvd_nx, nq_q, wd_q);
            rmd_d   = fix(rem_nx, nr_q, wd_q);
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (resp_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      nq_q        <= 1'b0;
      nr_q        <= 1'b0;
      wd_q        <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      nq_q        <= nq_d;
      nr_q        <= nr_d;
      wd_q        <= wd_d;
      quotient_o  <= quo_d;
      remainder_o <= rmd_d;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter (XLEN=64).
// Directed vectors; a negedge monitor checks every response.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [63:0] op_1_i = '0;
  logic [63:0] op_2_i = '0;
  logic        signed_i = 1'b0;
  logic        word_i = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [63:0] quotient_o;
  logic [63:0] remainder_o;

  div_iter #(.XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .op_1_i       (op_1_i),
    .op_2_i       (op_2_i),
    .signed_i     (signed_i),
    .word_i       (word_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   head_seen = 1'b0;

  function automatic void check(
    input string       nm,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, got, exp);
  endfunction

  function automatic void timeout(input string nm);
    n_chk++;
    $display("FAIL %s: timeout got none expected event",
             nm);
  endfunction

  always @(negedge clk) begin
    if (rst && resp_valid_o) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_resp: got q=%h r=%h",
                 quotient_o, remainder_o);
      end else begin
        if (!head_seen) begin
          check("latency", 64'(cyc - sb[0].acc),
                64'(sb[0].lat));
          head_seen = 1'b1;
        end
        check("quotient", quotient_o, sb[0].q);
        check("remainder", remainder_o, sb[0].r);
        if (resp_ready_i) begin
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        s,
    input logic        w,
    input logic [63:0] q,
    input logic [63:0] r,
    input int          lat,
    input bit          push
  );
    bit ok;
    exp_t e;
    ok = 1'b0;
    op_1_i = a;
    op_2_i = b;
    signed_i = s;
    word_i = w;
    req_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("accept");
    else if (push) begin
      e.q = q;
      e.r = r;
      e.lat = lat;
      e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    #1;
    check("rst_q", quotient_o, 64'h0);
    check("rst_r", remainder_o, 64'h0);
    check("rst_valid", 64'(resp_valid_o), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(req_ready_o), 64'h1);
    @(posedge clk);
    #1;
    stall_i = 1'b1;
    @(negedge clk);
    check("stall_ready", 64'(req_ready_o), 64'h0);
    @(posedge clk);
    #1;
    stall_i = 1'b0;

    issue(64'd100, 64'd7, 0, 0, 64'd14, 64'd2, 65, 1);
    wait_done(200);
    issue(-64'sd7, 64'd2, 1, 0,
          64'hFFFF_FFFF_FFFF_FFFD,
          64'hFFFF_FFFF_FFFF_FFFF, 65, 1);
    wait_done(200);
    issue(64'd7, -64'sd2, 1, 0,
          64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65, 1);
    wait_done(200);
    issue(64'd5, 64'd0, 0, 0,
          64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1, 1);
    wait_done(20);
    issue(64'h8000_0000_0000_0000,
          64'hFFFF_FFFF_FFFF_FFFF, 1, 0,
          64'h8000_0000_0000_0000, 64'd0, 1, 1);
    wait_done(20);
    issue(64'h1_FFFF_FFFF, 64'd1, 0, 1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33, 1);
    wait_done(100);
    issue(64'h8000_0000,
          64'hFFFF_FFFF_FFFF_FFFF, 1, 1,
          64'hFFFF_FFFF_8000_0000, 64'd0, 1, 1);
    wait_done(20);

    issue(64'd1000, 64'd10, 0, 0, 64'd100, 64'd0, 70, 1);
    repeat (10) @(posedge clk);
    #1;
    stall_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    stall_i = 1'b0;
    wait_done(200);

    resp_ready_i = 1'b0;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 0, 0,
          64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 65, 1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout("bp_valid");
    repeat (3) @(posedge clk);
    #1;
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_idle_ready", 64'(req_ready_o), 64'h1);
    wait_done(20);

    issue(64'd500, 64'd3, 0, 0, 64'd0, 64'd0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(resp_valid_o), 64'h0);
    check("flush_ready", 64'(req_ready_o), 64'h1);
    @(posedge clk);
    #1;
    issue(-64'sd100, 64'd7, 1, 0,
          64'hFFFF_FFFF_FFFF_FFF2,
          64'hFFFF_FFFF_FFFF_FFFE, 65, 1);
    wait_done(200);

    issue(64'd1000, 64'd3, 0, 0, 64'd0, 64'd0, 0, 0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_q", quotient_o, 64'h0);
    check("arst_r", remainder_o, 64'h0);
    check("arst_valid", 64'(resp_valid_o), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("arst_ready", 64'(req_ready_o), 64'h1);
    @(posedge clk);
    #1;
    issue(64'h1234_5678_FFFF_FFF7, 64'd4, 1, 1,
          64'hFFFF_FFFF_FFFF_FFFE,
          64'hFFFF_FFFF_FFFF_FFFF, 33, 1);
    wait_done(100);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
